// File: rtl/if_fetch_queue.sv
// Handshaked instruction fetch front end: 8-byte aligned imem requests, in-order responses,
// {pc, inst} queue to decode with redirect flush. Define IF_QUEUE_BYPASS_EN for a 0-cycle empty-queue bypass.
module if_fetch_queue #(
    parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000,
    parameter int          IQ_DEPTH = 4,
    parameter int          CNT_W    = $clog2(IQ_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [63:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int               PTR_W   = $clog2(IQ_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(IQ_DEPTH);

    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] qhd_q, qhd_d, qtl_q, qtl_d;
    logic [PTR_W-1:0] thd_q, ttl_q;

    logic [63:0] q_pc_q   [IQ_DEPTH];
    logic [31:0] q_inst_q [IQ_DEPTH];
    logic [63:0] tag_q    [IQ_DEPTH];

    logic           accept, resp, resp_keep, q_push, q_pop, q_empty, bypass;
    logic [63:0]    tag_pc;
    logic [31:0]    resp_inst;
    logic [CNT_W:0] credits;

    always_comb begin
        // Entries already queued plus live (non-dropped) requests must fit the queue.
        credits        = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, drop_q};
        imem_req_valid = !rst && !redirect_valid && (credits < DEPTH_X) && (outst_q < DEPTH_C);
        imem_req_addr  = {fetch_pc_q[63:3], 3'b000};
        accept         = imem_req_valid && imem_req_ready;
        resp           = !rst && imem_resp_valid;
        tag_pc         = tag_q[thd_q];
        resp_inst      = tag_pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
        resp_keep      = resp && !redirect_valid && (drop_q == '0);
        q_empty        = (count_q == '0);
`ifdef IF_QUEUE_BYPASS_EN
        bypass         = resp_keep && q_empty;
`else
        bypass         = 1'b0;
`endif
        out_valid = !rst && (!q_empty || bypass);
        out_pc    = '0;
        out_inst  = '0;
        if (!rst && !q_empty) begin
            out_pc   = q_pc_q[qhd_q];
            out_inst = q_inst_q[qhd_q];
        end else if (!rst && bypass) begin
            out_pc   = tag_pc;
            out_inst = resp_inst;
        end
        q_pop  = !rst && !q_empty && out_ready && !redirect_valid;
        q_push = resp_keep && !(bypass && out_ready);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CNT_W'(accept) - CNT_W'(resp);
        drop_d     = drop_q;
        count_d    = count_q + CNT_W'(q_push) - CNT_W'(q_pop);
        qhd_d      = qhd_q + PTR_W'(q_pop);
        qtl_d      = qtl_q + PTR_W'(q_push);
        if (redirect_valid) begin
            // Every request still in flight is stale; the same-cycle response is one of them.
            fetch_pc_d = redirect_pc & ~64'h3;
            drop_d     = outst_q - CNT_W'(resp);
            count_d    = '0;
            qhd_d      = '0;
            qtl_d      = '0;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 64'd4;
            if (resp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= PC_START;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            qhd_q      <= '0;
            qtl_q      <= '0;
            thd_q      <= '0;
            ttl_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            qhd_q      <= qhd_d;
            qtl_q      <= qtl_d;
            thd_q      <= thd_q + PTR_W'(resp);
            ttl_q      <= ttl_q + PTR_W'(accept);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_q[ttl_q] <= fetch_pc_q;
        if (q_push) begin
            q_pc_q[qtl_q]   <= tag_pc;
            q_inst_q[qtl_q] <= resp_inst;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) assert (!(resp_keep && count_q == DEPTH_C))
            else $error("instruction queue overflow: response arrived with queue full");
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: per-cycle vector table plus multi-cycle sequences,
// driven against an in-order latency memory model and a +4 PC scoreboard.
module tb_if_fetch_queue;

    localparam logic [63:0] PC_START   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] CONST_DATA = 64'hAAAA_BBBB_CCCC_DDDD;
`ifdef IF_QUEUE_BYPASS_EN
    localparam int OLAT = 2;
`else
    localparam int OLAT = 3;
`endif

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    if_fetch_queue dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        ordy;
        logic        exp_rv;
        logic [63:0] exp_addr;
        logic        exp_ov;
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    int          n_vec, n_miss, cyc, n_out, n_acc, lat_min, lat_max;
    logic        const_mode;
    logic [63:0] exp_pc;
    logic [63:0] mq_addr[$];
    int          mq_due[$];

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return const_mode ? CONST_DATA : {~a[31:0], a[31:0]};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] d;
        d = mem_data({pc[63:3], 3'b000});
        return pc[2] ? d[63:32] : d[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Present this cycle's memory response, then let combinational outputs settle.
    task automatic drive();
        imem_resp_valid = !rst && mq_addr.size() > 0 && mq_due[0] <= cyc;
        imem_resp_data  = imem_resp_valid ? mem_data(mq_addr[0]) : 64'h0;
        #1;
    endtask

    // Record this cycle's handshakes in the memory model and scoreboard, then advance.
    task automatic commit();
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
            exp_pc = PC_START;
        end else begin
            if (imem_resp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                n_acc++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
            else if (out_valid && out_ready) begin
                chk("sb_out_pc", out_pc, exp_pc);
                chk("sb_out_inst", {32'h0, out_inst}, {32'h0, exp_inst(exp_pc)});
                exp_pc += 64'd4;
                n_out++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        drive();
        commit();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Run until the first output handshake (bounded) and check its PC.
    task automatic wait_first(input string nm, input logic [63:0] want);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            drive();
            if (out_valid && out_ready) begin
                chk(nm, out_pc, want);
                got = 1'b1;
            end
            commit();
        end
        if (!got) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    vec_t tv[12];

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0; n_out = 0; n_acc = 0;
        lat_min = 1; lat_max = 1; const_mode = 1'b1; exp_pc = PC_START;
        rst = 1'b1; imem_req_ready = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_resp_valid = 1'b0; imem_resp_data = '0;

        // Reset, then 1-cycle memory returning a constant doubleword, decode always ready.
        for (int i = 0; i < 12; i++) begin
            tv[i] = '0;
            if (i < 2) tv[i].rst = 1'b1;
            else begin
                int k;
                k = i - 1;
                tv[i].rdy      = 1'b1;
                tv[i].ordy     = 1'b1;
                tv[i].exp_rv   = 1'b1;
                tv[i].exp_addr = (PC_START + 64'(4 * (k - 1))) & ~64'h7;
                if (k >= OLAT) begin
                    tv[i].exp_ov   = 1'b1;
                    tv[i].exp_pc   = PC_START + 64'(4 * (k - OLAT));
                    tv[i].exp_inst = tv[i].exp_pc[2] ? 32'hAAAA_BBBB : 32'hCCCC_DDDD;
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            rst = tv[i].rst; imem_req_ready = tv[i].rdy; out_ready = tv[i].ordy;
            drive();
            chk("tv_req_valid", {63'h0, imem_req_valid}, {63'h0, tv[i].exp_rv});
            if (tv[i].exp_rv) chk("tv_req_addr", imem_req_addr, tv[i].exp_addr);
            chk("tv_out_valid", {63'h0, out_valid}, {63'h0, tv[i].exp_ov});
            chk("tv_out_pc", out_pc, tv[i].exp_pc);
            chk("tv_out_inst", {32'h0, out_inst}, {32'h0, tv[i].exp_inst});
            commit();
        end

        // Decode stalled: credits cap accepted requests at the queue depth.
        const_mode = 1'b0;
        out_ready = 1'b0;
        do_reset();
        imem_req_ready = 1'b1;
        n_acc = 0;
        repeat (20) step();
        drive();
        chk("stall_accepts", 64'(n_acc), 64'd4);
        chk("stall_req_valid", {63'h0, imem_req_valid}, 64'd0);
        chk("stall_out_valid", {63'h0, out_valid}, 64'd1);
        chk("stall_out_pc", out_pc, PC_START);
        commit();
        out_ready = 1'b1;
        n_out = 0;
        repeat (30) step();
        chk("stall_drain", 64'(n_out >= 20), 64'd1);

        // Redirect with three slow requests in flight.
        lat_min = 5; lat_max = 5;
        do_reset();
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_1006;
        drive();
        chk("redir_req_valid", {63'h0, imem_req_valid}, 64'd0);
        commit();
        redirect_valid = 1'b0;
        drive();
        chk("redir_next_rv", {63'h0, imem_req_valid}, 64'd1);
        chk("redir_next_addr", imem_req_addr, 64'h0000_0000_8000_1000);
        chk("redir_empty", {63'h0, out_valid}, 64'd0);
        commit();
        for (int i = 0; i < 4; i++) begin
            drive();
            chk("redir_stale_drop", {63'h0, out_valid}, 64'd0);
            commit();
        end
        wait_first("redir_first_pc", 64'h0000_0000_8000_1004);
        repeat (20) step();

        // Redirect coinciding with a response and a decode pop.
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (5) step();
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_2000;
        drive();
        chk("rpop_resp_present", {63'h0, imem_resp_valid}, 64'd1);
        chk("rpop_req_valid", {63'h0, imem_req_valid}, 64'd0);
        commit();
        redirect_valid = 1'b0;
        drive();
        chk("rpop_flushed", {63'h0, out_valid}, 64'd0);
        commit();
        wait_first("rpop_first_pc", 64'h0000_0000_8000_2000);
        repeat (20) step();

        // PC wrap-around at the top of the address space.
        lat_min = 1; lat_max = 1;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        wait_first("wrap_first_pc", 64'hFFFF_FFFF_FFFF_FFFC);
        n_out = 0;
        repeat (10) step();
        chk("wrap_progress", 64'(n_out >= 3), 64'd1);

        // Random ready/latency/redirect traffic checked by the scoreboard.
        lat_min = 1; lat_max = 4;
        n_out = 0;
        for (int i = 0; i < 1000; i++) begin
            imem_req_ready = 1'($urandom_range(1, 0));
            out_ready      = 1'($urandom_range(1, 0));
            redirect_valid = ($urandom_range(49, 0) == 0);
            redirect_pc    = {32'h0, $urandom};
            step();
        end
        redirect_valid = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (20) step();
        chk("rand_progress", 64'(n_out > 50), 64'd1);

        // Reset in the middle of traffic.
        rst = 1'b1;
        drive();
        chk("midrst_req_valid", {63'h0, imem_req_valid}, 64'd0);
        chk("midrst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("midrst_out_pc", out_pc, 64'd0);
        chk("midrst_out_inst", {32'h0, out_inst}, 64'd0);
        commit();
        rst = 1'b0;
        wait_first("midrst_first_pc", PC_START);
        repeat (10) step();

`ifdef IF_QUEUE_BYPASS_EN
        // Empty queue: a response goes straight to decode in its own cycle.
        lat_min = 1; lat_max = 1;
        do_reset();
        step();
        drive();
        chk("byp_out_valid", {63'h0, out_valid}, 64'd1);
        chk("byp_out_pc", out_pc, PC_START);
        chk("byp_out_inst", {32'h0, out_inst}, {32'h0, exp_inst(PC_START)});
        commit();
        drive();
        chk("byp_next_pc", out_pc, PC_START + 64'd4);
        commit();
        repeat (10) step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
